// File: rtl/seven_seg_scanner_if.sv
// Bus bundle for the seven_seg_scanner: value/control inputs from the datapath
// side and the multiplexed display pins plus load handshake back.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    negative;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [6:0]              segments;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    frame_done;
  logic                    busy;

  modport master (
    output en, load, digits, negative, blank_lz, dp_mask, blink_mask,
    input  segments, dp, anodes, frame_done, busy
  );

  modport slave (
    input  en, load, digits, negative, blank_lz, dp_mask, blink_mask,
    output segments, dp, anodes, frame_done, busy
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment driver with hex decode,
// leading-zero blanking, per-digit dp/blink and a double-buffered value load.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 250000,
  parameter int BLINK_TICKS = 512,
  parameter bit SIGN_EN     = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seven_seg_scanner_if.slave bus
);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W   = $clog2(REFRESH_DIV);
  localparam int BLK_W   = $clog2(BLINK_TICKS + 1);
  localparam int NUM_VAL = SIGN_EN ? NUM_DIGITS - 1 : NUM_DIGITS;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(BLINK_TICKS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;  4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;  4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;  4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;  4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;  4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;  4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;  4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;  4'hF: hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  logic [PRE_W-1:0]        prescaler_r;
  logic [IDX_W-1:0]        index_r;
  logic [BLK_W-1:0]        tick_cnt_r;
  logic                    blink_phase_r;
  logic [4*NUM_DIGITS-1:0] pend_digits_r, disp_digits_r;
  logic                    pend_neg_r, disp_neg_r;
  logic                    pend_lz_r, disp_lz_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r, disp_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blink_r, disp_blink_r;
  logic                    busy_r, frame_done_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   anodes_r;

  logic                    tick_s, wrap_s, blink_off_s;
  logic [3:0]              nib_s;
  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic [6:0]              digit_seg_s, seg_s;
  logic                    dp_s;
  logic [NUM_DIGITS-1:0]   anodes_s;

  assign tick_s = (prescaler_r == PRE_LAST);
  assign wrap_s = tick_s && (index_r == IDX_LAST);

  // Refresh prescaler, scan index and blink timebase; free-running regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_r   <= '0;
      index_r       <= '0;
      tick_cnt_r    <= '0;
      blink_phase_r <= 1'b0;
    end else if (tick_s) begin
      prescaler_r <= '0;
      index_r     <= wrap_s ? '0 : index_r + IDX_W'(1);
      if (tick_cnt_r == BLK_LAST) begin
        tick_cnt_r    <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        tick_cnt_r <= tick_cnt_r + BLK_W'(1);
      end
    end else begin
      prescaler_r <= prescaler_r + PRE_W'(1);
    end
  end

  // Pending/display double buffer; the swap reads the old pending so a load on the wrap cycle waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits_r <= '0;  disp_digits_r <= '0;
      pend_neg_r    <= 1'b0; disp_neg_r   <= 1'b0;
      pend_lz_r     <= 1'b0; disp_lz_r    <= 1'b0;
      pend_dp_r     <= '0;  disp_dp_r     <= '0;
      pend_blink_r  <= '0;  disp_blink_r  <= '0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      frame_done_r <= wrap_s && busy_r;
      if (wrap_s && busy_r) begin
        disp_digits_r <= pend_digits_r;
        disp_neg_r    <= pend_neg_r;
        disp_lz_r     <= pend_lz_r;
        disp_dp_r     <= pend_dp_r;
        disp_blink_r  <= pend_blink_r;
      end
      if (bus.load) begin
        pend_digits_r <= bus.digits;
        pend_neg_r    <= bus.negative;
        pend_lz_r     <= bus.blank_lz;
        pend_dp_r     <= bus.dp_mask;
        pend_blink_r  <= bus.blink_mask;
        busy_r        <= 1'b1;
      end else if (wrap_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Leading-zero mask: walk value positions from the top while every nibble seen so far is zero.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    lz_blank_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i < NUM_VAL) begin
        zero_run      = zero_run & (disp_digits_r[4*i +: 4] == 4'h0);
        lz_blank_s[i] = disp_lz_r & zero_run & (i > 0);
      end else begin
        lz_blank_s[i] = 1'b0;
      end
    end
  end

  // Next pin values for the digit currently selected by the scan index.
  always_comb begin
    nib_s       = disp_digits_r[{index_r, 2'b00} +: 4];
    blink_off_s = blink_phase_r & disp_blink_r[index_r];
    if (SIGN_EN && (index_r == IDX_LAST)) begin
      digit_seg_s = disp_neg_r ? 7'h3F : 7'h7F;
    end else if (lz_blank_s[index_r]) begin
      digit_seg_s = 7'h7F;
    end else begin
      digit_seg_s = hex_to_seg(nib_s);
    end
    if (!bus.en) begin
      seg_s    = 7'h7F;
      dp_s     = 1'b1;
      anodes_s = {NUM_DIGITS{1'b1}};
    end else begin
      seg_s    = blink_off_s ? 7'h7F : digit_seg_s;
      dp_s     = ~(disp_dp_r[index_r] & ~blink_off_s);
      anodes_s = ~(ONE_HOT0 << index_r);
    end
  end

  // Registered display pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r    <= 7'h7F;
      dp_r     <= 1'b1;
      anodes_r <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r    <= seg_s;
      dp_r     <= dp_s;
      anodes_r <= anodes_s;
    end
  end

  assign bus.segments   = seg_r;
  assign bus.dp         = dp_r;
  assign bus.anodes     = anodes_r;
  assign bus.frame_done = frame_done_r;
  assign bus.busy       = busy_r;
endmodule
